// File: rtl/i2c_bit_pkg.sv
// i2c_bit_pkg: shared types and constants for the I2C bit engine.
package i2c_bit_pkg;

    localparam int PHASES = 4;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_SYNC = 3'd3,
        ST_ARM2 = 3'd4
    } bit_state_t;

endpackage

// File: rtl/i2c_bit_engine_if.sv
// i2c_bit_engine_if: command handshake from the byte controller plus the
// open-drain bus lines. The engine uses the slave modport.
interface i2c_bit_engine_if #(
    parameter int TIMER_WIDTH = 8
);
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic [1:0]             cmd_i;
    logic                   data_i;
    logic [TIMER_WIDTH-1:0] quarter_i;
    logic                   done_o;
    logic                   rx_bit_o;
    logic                   arb_lost_o;
    logic                   scl_i;
    logic                   sda_i;
    logic                   scl_oe_o;
    logic                   sda_oe_o;

    modport slave (
        input  cmd_valid_i, cmd_i, data_i, quarter_i, scl_i, sda_i,
        output cmd_ready_o, done_o, rx_bit_o, arb_lost_o, scl_oe_o, sda_oe_o
    );

    modport master (
        output cmd_valid_i, cmd_i, data_i, quarter_i, scl_i, sda_i,
        input  cmd_ready_o, done_o, rx_bit_o, arb_lost_o, scl_oe_o, sda_oe_o
    );
endinterface

// File: rtl/i2c_phase_thresholds.sv
// i2c_phase_thresholds: maps a quarter period to cumulative timer thresholds
// {q, 2q, 3q, 4q} (or {q, 2q, 3q, 3q} for the second run), q = max(q_i, 1),
// saturating each to all-ones. Purely combinational.
module i2c_phase_thresholds #(
    parameter int TIMER_WIDTH = 8,
    parameter int PHASES      = 4
) (
    input  logic [TIMER_WIDTH-1:0]             q_i,
    input  logic                               run2_i,
    output logic [PHASES-1:0][TIMER_WIDTH-1:0] set_o
);
    // Two extra bits hold 4 * (2^W - 1) without wrapping.
    localparam int EW = TIMER_WIDTH + 2;

    logic [EW-1:0] q_ext;
    logic [EW-1:0] acc;

    // Running sum of q per phase; the last phase of run 2 repeats the previous sum.
    always_comb begin
        q_ext = (q_i == '0) ? EW'(1) : EW'(q_i);
        acc   = '0;
        set_o = '0;
        for (int k = 0; k < PHASES; k++) begin
            if (!(run2_i && (k == PHASES - 1))) begin
                acc = acc + q_ext;
            end
            set_o[k] = (acc[EW-1:TIMER_WIDTH] != '0) ? '1 : acc[TIMER_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: executes one I2C bit command (START/STOP/WRITE/READ) by
// programming an external phase timer and stepping SCL/SDA on its expired
// flags. Define I2C_CLOCK_STRETCH_EN to wait for SCL high after release and
// finish the bit with a second timer run.
//
// state | meaning
// IDLE  | ready for a command, lines hold their last level
// ARM   | pulse timer start, flags are stale and ignored
// RUN   | phase counter advances on expired_i[phase]
// SYNC  | (stretch) wait for the bus to show SCL high
// ARM2  | (stretch) pulse timer start for the second run
module i2c_bit_engine #(
    parameter int TIMER_WIDTH = 8,
    parameter int PHASES      = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    i2c_bit_engine_if.slave                    bus,
    output logic [PHASES-1:0][TIMER_WIDTH-1:0] timer_set_o,
    output logic                               timer_start_o,
    input  logic [PHASES-1:0]                  expired_i
);
    import i2c_bit_pkg::*;

    bit_state_t                         state_q, state_d;
    cmd_t                               cmd_q, cmd_d;
    logic                               data_q, data_d;
    logic [1:0]                         phase_q, phase_d;
    logic [PHASES-1:0][TIMER_WIDTH-1:0] set_q, set_d;
    logic                               scl_oe_q, scl_oe_d;
    logic                               sda_oe_q, sda_oe_d;
    logic                               done_q, done_d;
    logic                               rx_q, rx_d;
    logic                               arb_q, arb_d;

    logic [PHASES-1:0][TIMER_WIDTH-1:0] thr;
    logic [TIMER_WIDTH-1:0]             thr_q_in;
    logic                               thr_run2;
    logic [1:0]                         act;
    logic                               accept;

`ifdef I2C_CLOCK_STRETCH_EN
    logic [TIMER_WIDTH-1:0] quarter_q, quarter_d;
    logic                   run2_q, run2_d;

    // Second run reuses the quarter latched at accept; its phases shift up by one action.
    assign thr_q_in      = (state_q == ST_IDLE) ? bus.quarter_i : quarter_q;
    assign thr_run2      = (state_q != ST_IDLE);
    assign act           = run2_q ? (phase_q + 2'd1) : phase_q;
    assign timer_start_o = (state_q == ST_ARM) || (state_q == ST_ARM2);
`else
    assign thr_q_in      = bus.quarter_i;
    assign thr_run2      = 1'b0;
    assign act           = phase_q;
    assign timer_start_o = (state_q == ST_ARM);
`endif

    i2c_phase_thresholds #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .PHASES      (PHASES)
    ) u_thresholds (
        .q_i    (thr_q_in),
        .run2_i (thr_run2),
        .set_o  (thr)
    );

    assign accept          = bus.cmd_valid_i && (state_q == ST_IDLE);
    assign bus.cmd_ready_o = (state_q == ST_IDLE);
    assign bus.done_o      = done_q;
    assign bus.rx_bit_o    = rx_q;
    assign bus.arb_lost_o  = arb_q;
    assign bus.scl_oe_o    = scl_oe_q;
    assign bus.sda_oe_o    = sda_oe_q;
    assign timer_set_o     = set_q;

    // Next-state and line actions; one phase action per expired flag.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        phase_d  = phase_q;
        set_d    = set_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        done_d   = 1'b0;
        arb_d    = 1'b0;
        rx_d     = rx_q;
`ifdef I2C_CLOCK_STRETCH_EN
        quarter_d = quarter_q;
        run2_d    = run2_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d   = cmd_t'(bus.cmd_i);
                    data_d  = bus.data_i;
                    set_d   = thr;
                    phase_d = '0;
                    state_d = ST_ARM;
`ifdef I2C_CLOCK_STRETCH_EN
                    quarter_d = bus.quarter_i;
                    run2_d    = 1'b0;
`endif
                    // SCL is left alone for START/STOP so a repeated start works from low SCL.
                    case (cmd_t'(bus.cmd_i))
                        CMD_START: sda_oe_d = 1'b0;
                        CMD_STOP:  sda_oe_d = 1'b1;
                        CMD_WRITE: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = !bus.data_i;
                        end
                        default: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_ARM: state_d = ST_RUN;
            ST_RUN: begin
                if (expired_i[phase_q]) begin
                    phase_d = phase_q + 2'd1;
                    case (act)
                        2'd0: begin
                            scl_oe_d = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
                            state_d  = ST_SYNC;
`endif
                        end
                        2'd1: begin
                            case (cmd_q)
                                CMD_START: sda_oe_d = 1'b1;
                                CMD_STOP:  sda_oe_d = 1'b0;
                                CMD_READ:  rx_d     = bus.sda_i;
                                default: begin
                                    // Released SDA seen low: another master owns the bus.
                                    if (data_q && !bus.sda_i) begin
                                        scl_oe_d = 1'b0;
                                        sda_oe_d = 1'b0;
                                        done_d   = 1'b1;
                                        arb_d    = 1'b1;
                                        state_d  = ST_IDLE;
                                    end
                                end
                            endcase
                        end
                        2'd2: begin
                            if (cmd_q != CMD_STOP) begin
                                scl_oe_d = 1'b1;
                            end
                        end
                        default: begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
`ifdef I2C_CLOCK_STRETCH_EN
            ST_SYNC: begin
                if (bus.scl_i) begin
                    set_d   = thr;
                    phase_d = '0;
                    run2_d  = 1'b1;
                    state_d = ST_ARM2;
                end
            end
            ST_ARM2: state_d = ST_RUN;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CMD_START;
            data_q   <= 1'b0;
            phase_q  <= '0;
            set_q    <= '0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            done_q   <= 1'b0;
            rx_q     <= 1'b0;
            arb_q    <= 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
            quarter_q <= '0;
            run2_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            phase_q  <= phase_d;
            set_q    <= set_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            done_q   <= done_d;
            rx_q     <= rx_d;
            arb_q    <= arb_d;
`ifdef I2C_CLOCK_STRETCH_EN
            quarter_q <= quarter_d;
            run2_q    <= run2_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb_i2c_bit_engine: drives bit commands, models the phase timer and the
// open-drain bus, and checks each completion against a scoreboard entry
// computed from the command, the quarter period and the timer thresholds.
module tb_i2c_bit_engine;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0][TW-1:0] tset;
    logic            tstart;
    logic [3:0]      texp;
    logic            ext_low;
    int              cyc = 0;
    int              n_assert = 0;
    int              n_fail = 0;
    logic            rx_m;

    typedef struct {
        int   cyc;
        logic rx;
        logic arb;
        logic scl_oe;
        logic sda_oe;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    i2c_bit_engine_if #(.TIMER_WIDTH(TW)) bus ();

    i2c_bit_engine #(.TIMER_WIDTH(TW), .PHASES(4)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .bus           (bus),
        .timer_set_o   (tset),
        .timer_start_o (tstart),
        .expired_i     (texp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Open-drain bus: a line is high unless someone pulls it low.
    assign bus.scl_i = ~bus.scl_oe_o;
    assign bus.sda_i = ~bus.sda_oe_o & ~ext_low;

    // Phase timer: counts clocks from a start rising edge; flag i is high once count >= threshold i.
    logic start_prev;
    logic trun;
    int   tcnt;
    always @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b0;
            trun       <= 1'b0;
            tcnt       <= 0;
            texp       <= '0;
        end else begin
            start_prev <= tstart;
            if (tstart && !start_prev) begin
                trun <= 1'b1;
                tcnt <= 1;
                texp <= '0;
            end else if (trun) begin
                tcnt <= tcnt + 1;
                for (int i = 0; i < 4; i++) texp[i] <= (tcnt >= int'(tset[i]));
            end
        end
    end

    // Bus condition counters: SDA edges while SCL stays high.
    logic scl_prev, sda_prev;
    int   n_startc = 0;
    int   n_stopc = 0;
    always @(negedge clk) begin
        if (scl_prev === 1'b1 && bus.scl_i && sda_prev === 1'b1 && !bus.sda_i) n_startc <= n_startc + 1;
        if (scl_prev === 1'b1 && bus.scl_i && sda_prev === 1'b0 && bus.sda_i) n_stopc <= n_stopc + 1;
        scl_prev <= bus.scl_i;
        sda_prev <= bus.sda_i;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endfunction

    function automatic int sat_thr(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Completion offset from accept: phase i ends when its flag is up and the previous phase is done.
    function automatic int exp_latency(input logic [7:0] qv, input bit arb);
        int q, t, s;
        q = (qv == 0) ? 1 : int'(qv);
        t = 1;
        for (int i = 0; i < 4; i++) begin
            s = sat_thr((i + 1) * q);
            t = (s + 2 > t + 1) ? s + 2 : t + 1;
            if (arb && i == 1) return t + 1;
        end
        return t + 1;
    endfunction

    // Scoreboard monitor: every done pulse consumes one expected completion.
    always @(negedge clk) begin
        if (!rst && bus.done_o) begin
            chk("done_expected", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("rx_bit", bus.rx_bit_o, mon_e.rx);
                chk("arb_lost", bus.arb_lost_o, mon_e.arb);
                chk("scl_oe_at_done", bus.scl_oe_o, mon_e.scl_oe);
                chk("sda_oe_at_done", bus.sda_oe_o, mon_e.sda_oe);
                chk("ready_at_done", bus.cmd_ready_o, 1);
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic d, input logic [7:0] qv,
                         input logic ext, input bit wait_done);
        exp_t e;
        bit   arb;
        bit   got;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i       = c;
        bus.data_i      = d;
        bus.quarter_i   = qv;
        ext_low         = ext;
        arb = (c == 2'd2) && d && ext;
        if (c == 2'd3) rx_m = !ext;
        e.cyc = cyc + exp_latency(qv, arb);
        e.rx  = rx_m;
        e.arb = arb;
        case (c)
            2'd0:    begin e.scl_oe = 1'b1; e.sda_oe = 1'b1; end
            2'd1:    begin e.scl_oe = 1'b0; e.sda_oe = 1'b0; end
            2'd2:    begin e.scl_oe = !arb; e.sda_oe = arb ? 1'b0 : !d; end
            default: begin e.scl_oe = 1'b1; e.sda_oe = 1'b0; end
        endcase
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 2'($urandom);
        bus.data_i      = 1'($urandom);
        bus.quarter_i   = 8'($urandom);
        chk("ready_while_busy", bus.cmd_ready_o, 0);
        chk("timer_start_pulse", tstart, 1);
        @(posedge clk); #1;
        chk("timer_start_single", tstart, 0);
        if (wait_done) begin
            got = 1'b0;
            for (int k = 0; k < 700 && !got; k++) begin
                @(negedge clk);
                got = bus.done_o;
            end
            chk("done_seen", got, 1);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_scl_oe"}, bus.scl_oe_o, 0);
        chk({tag, "_sda_oe"}, bus.sda_oe_o, 0);
        chk({tag, "_done"}, bus.done_o, 0);
        chk({tag, "_rx_bit"}, bus.rx_bit_o, 0);
        chk({tag, "_arb_lost"}, bus.arb_lost_o, 0);
        chk({tag, "_timer_start"}, tstart, 0);
        chk({tag, "_timer_set"}, tset, 0);
        chk({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
    endtask

    initial begin
        logic [3:0][TW-1:0] ev;
        logic [1:0] c;
        logic d, ext;
        logic [7:0] qv;
        int sc0, pc0;

        rst             = 1'b1;
        ext_low         = 1'b0;
        rx_m            = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 2'd0;
        bus.data_i      = 1'b0;
        bus.quarter_i   = 8'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // START then STOP from idle: one start and one stop condition on the bus.
        sc0 = n_startc;
        pc0 = n_stopc;
        issue(2'd0, 1'b0, 8'd3, 1'b0, 1);
        issue(2'd1, 1'b0, 8'd3, 1'b0, 1);
        @(negedge clk);
        chk("start_condition", n_startc - sc0, 1);
        chk("stop_condition", n_stopc - pc0, 1);

        // WRITE 1 with a free bus, READ with SDA low then high, WRITE 1 losing arbitration.
        issue(2'd2, 1'b1, 8'd5, 1'b0, 1);
        issue(2'd3, 1'b0, 8'd5, 1'b1, 1);
        issue(2'd3, 1'b0, 8'd5, 1'b0, 1);
        issue(2'd2, 1'b1, 8'd5, 1'b1, 1);

        // Saturated thresholds, and quarter 0 treated as 1.
        issue(2'd2, 1'b0, 8'd200, 1'b0, 1);
        for (int i = 0; i < 4; i++) ev[i] = 8'(sat_thr((i + 1) * 200));
        chk("thresholds_q200", tset, ev);
        issue(2'd2, 1'b0, 8'd0, 1'b0, 1);
        for (int i = 0; i < 4; i++) ev[i] = 8'(i + 1);
        chk("thresholds_q0", tset, ev);

        // Reset in the middle of a bit, then a normal WRITE.
        issue(2'd2, 1'b0, 8'd10, 1'b0, 0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrun_reset");
        rst = 1'b0;
        sbq.delete();
        rx_m    = 1'b0;
        ext_low = 1'b0;
        @(negedge clk);
        issue(2'd2, 1'b1, 8'd4, 1'b0, 1);

        // Random back-to-back commands.
        for (int n = 0; n < 40; n++) begin
            c   = 2'($urandom_range(0, 3));
            d   = 1'($urandom);
            ext = 1'($urandom);
            qv  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(60, 255)) : 8'($urandom_range(0, 12));
            issue(c, d, qv, ext, 1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_bit_engine.md
Name: i2c_bit_engine

Overview:
- Bit-level I2C sequencer sitting directly upstream of the multi-threshold phase timer in the i2c_master datapath.
- Accepts one bit command at a time (START, STOP, WRITE, READ) from the byte controller.
- Programs four cumulative phase thresholds into the timer, pulses its start input and advances SCL/SDA phases on the timer's expired flags.
- Drives open-drain enables, samples SDA and detects arbitration loss.

Parameters:
TIMER_WIDTH, 8, width of quarter-period input and timer thresholds; must match the timer instance.
PHASES, 4, number of timer thresholds; fixed at 4, parameterised only for the timer hookup.

Ports:
clock_i  input  1  single system clock, all logic on rising edge
reset_i  input  1  synchronous, active-high reset
quarter_i  input  TIMER_WIDTH  SCL quarter period in clocks; sampled at command accept
cmd_valid_i  input  1  command request
cmd_ready_o  output  1  high only in IDLE; command accepted when valid && ready
cmd_i  input  2  0=START, 1=STOP, 2=WRITE, 3=READ
data_i  input  1  bit to write (WRITE only); sampled at accept
done_o  output  1  one-cycle pulse at command completion
rx_bit_o  output  1  sampled SDA for READ; held until next READ completes
arb_lost_o  output  1  one-cycle pulse together with done_o when WRITE arbitration is lost
scl_i, sda_i  input  1 each  synchronised bus line levels
scl_oe_o, sda_oe_o  output  1 each  1 = pull line low, 0 = release
timer_set_o  output  TIMER_WIDTH x PHASES  thresholds to timer
timer_start_o  output  1  timer start; timer acts on its rising edge
expired_i  input  PHASES  timer expired flags

Behaviour:
- Reset values: scl_oe_o=0, sda_oe_o=0, done_o=0, rx_bit_o=0, arb_lost_o=0, timer_start_o=0, timer_set_o all '0, state IDLE, cmd_ready_o=1.
- Reset mid-operation releases both lines on the next edge.
- Thresholds (run 1): {q, 2q, 3q, 4q}, with q = max(quarter_i, 1).
  - Computed in TIMER_WIDTH+2 bits.
  - Any value above all-ones saturates to all-ones.
  - Latched at accept and held until the next accept.
- States:
  - IDLE: on accept, latch cmd/data/thresholds -> ARM.
  - ARM: timer_start_o=1 for exactly one cycle; expired_i ignored (stale) -> RUN.
  - RUN: timer_start_o=0; phase counter 0..3 advances on expired_i[phase].
  - On expired_i[3]: register done_o=1 -> IDLE.
- Latency: done_o asserts exactly 4q+3 cycles after the accept cycle; cmd_ready_o is high in the same cycle as done_o.
- Line sequences:
  - Between commands, SCL keeps its last level: low after START/WRITE/READ, released after STOP.
  - WRITE b:
    - sda_oe=!b for the whole bit; SCL low until exp[0], released at exp[0], pulled low at exp[2].
    - At exp[1], if b=1 and sda_i=0: release both lines, pulse arb_lost_o with done_o on the next cycle, -> IDLE.
  - READ: SDA released; SCL as WRITE; rx_bit_o <= sda_i at exp[1].
  - START:
    - SDA released during P0; SCL released at exp[0].
    - SDA pulled low at exp[1] (start condition); SCL pulled low at exp[2].
    - Issuing START after any command produces a repeated start.
  - STOP: SDA pulled low during P0; SCL released at exp[0]; SDA released at exp[1]; both remain released.
- Simultaneous flags: only expired_i[phase] is examined. Later flags seen in the same cycle are consumed one per cycle.
- Commands presented while busy are not accepted (cmd_ready_o=0).

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined:
  - After SCL is released at exp[0], enter SYNC and wait until scl_i=1 (no timeout).
  - Then ARM2: issue a second timer run with thresholds {q, 2q, 3q, 3q}.
  - In the second run, indices 0/1/2 act as sample / SCL-low / end.
  - Latency becomes (stretch cycles) + 4q + 4 or more.
- Undefined: single run; scl_i only affects nothing; SYNC/ARM2 states are absent from the RTL.

Decomposition:
- Package i2c_bit_pkg holds:
  - cmd_t enum (START, STOP, WRITE, READ).
  - bit_state_t enum (IDLE, ARM, RUN, SYNC, ARM2).
  - Constant PHASES=4.
- Sub-module i2c_phase_thresholds: purely combinational. Maps q, plus a run-select input for the stretch feature, to saturated thresholds.
- The timer is instantiated by the parent, not inside this block.

Test Plan:
- q=5, WRITE 1, bus follows the enables:
  - SCL low for 5 clocks, then released; sda_oe_o=0 throughout.
  - done_o at accept+23; arb_lost_o=0.
- q=5, READ, sda_i forced 0 around exp[1]: rx_bit_o=0 after done_o. Repeat with sda_i=1: rx_bit_o=1.
- WRITE 1 with sda_i held 0 externally: arb_lost_o and done_o pulse together; scl_oe_o=sda_oe_o=0; cmd_ready_o=1.
- START then STOP from idle (q=3):
  - SDA falls while SCL is released (START); SDA rises while SCL is released (STOP).
  - Lines end released.
- quarter_i=200 with TIMER_WIDTH=8: thresholds saturate to {200, 255, 255, 255}; quarter_i=0 behaves as 1 (done at accept+7).
- reset_i asserted mid-RUN: next cycle all outputs at reset values; a new WRITE completes normally.
